// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: FSM state and grant encodings shared by the multiplier arbiter.
package mult_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} arb_state_t;
  localparam logic GNT_R0 = 1'b0;
  localparam logic GNT_R1 = 1'b1;
endpackage

// File: rtl/multiplicador.sv
// multiplicador: combinational unsigned multiplier with upper-half overflow flag.
module multiplicador #(
  parameter int BIT = 4
) (
  input  logic [BIT-1:0]   num1,
  input  logic [BIT-1:0]   num2,
  output logic [2*BIT-1:0] Result,
  output logic             OFLOW
);
  assign Result = {{BIT{1'b0}}, num1} * {{BIT{1'b0}}, num2};
  assign OFLOW  = |Result[2*BIT-1:BIT];
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one multiplicador between two requesters.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [BIT-1:0]   a0,
  input  logic [BIT-1:0]   b0,
  input  logic             req1,
  input  logic [BIT-1:0]   a1,
  input  logic [BIT-1:0]   b1,
  output logic             ack0,
  output logic             ack1,
  output logic [2*BIT-1:0] result,
  output logic             oflow,
  output logic             busy
);
  arb_state_t state;
  logic grant, last_grant, win, ovf;
  logic [BIT-1:0] opa, opb;
  logic [2*BIT-1:0] prod;
  // on a tie the requester that was not served last goes next
  always_comb win = (req0 && req1) ? ~last_grant : (req1 ? GNT_R1 : GNT_R0);
  multiplicador #(.BIT(BIT)) u_mul (
    .num1(opa),
    .num2(opb),
    .Result(prod),
    .OFLOW(ovf)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      oflow      <= 1'b0;
      grant      <= GNT_R0;
      last_grant <= GNT_R1;
      opa        <= '0;
      opb        <= '0;
    end else begin
      case (state)
        IDLE: if (req0 || req1) begin
          grant <= win;
          opa   <= (win == GNT_R1) ? a1 : a0;
          opb   <= (win == GNT_R1) ? b1 : b0;
          busy  <= 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          result <= prod;
          oflow  <= ovf;
          ack0   <= (grant == GNT_R0);
          ack1   <= (grant == GNT_R1);
          state  <= DONE;
        end
        DONE: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          busy       <= 1'b0;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_mult_arbiter;
  logic clk = 0, rst = 1;
  logic req0 = 0, req1 = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic ack0, ack1, oflow, busy;
  logic [7:0] result;
  int checks = 0, errors = 0;

  typedef struct {bit id; logic [7:0] r; logic o;} exp_t;
  exp_t sb[$];

  mult_arbiter #(.BIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .result(result), .oflow(oflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ack0 && ack1) chk("ack_overlap", 1, 0);
      if (ack0 || ack1) begin
        if (sb.size() == 0) chk("unexpected_ack", {ack1, ack0}, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_id", {31'd0, ack1}, {31'd0, e.id});
          chk("result", {24'd0, result}, {24'd0, e.r});
          chk("oflow", {31'd0, oflow}, {31'd0, e.o});
        end
      end
    end
  end

  task automatic single(input bit id, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] alt, input logic [7:0] er, input logic eo);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    @(negedge clk);
    sb.push_back('{id, er, eo});
    if (id) begin a1 = a; b1 = b; req1 = 1; end
    else begin a0 = a; b0 = b; req0 = 1; end
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("busy_exec", {31'd0, busy}, 1);
        if (id) a1 = alt; else a0 = alt;
      end
      if (id ? ack1 : ack0) got = 1;
    end
    if (id) req1 = 0; else req0 = 0;
    chk("single_latency", got ? lat : 99, 2);
  endtask

  task automatic pair(input logic [3:0] x0, input logic [3:0] y0, input logic [7:0] r0, input logic o0,
                      input logic [3:0] x1, input logic [3:0] y1, input logic [7:0] r1, input logic o1);
    int n, t0, t1;
    n = 0;
    t0 = 0;
    t1 = 0;
    @(negedge clk);
    sb.push_back('{1'b0, r0, o0});
    sb.push_back('{1'b1, r1, o1});
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    req0 = 1; req1 = 1;
    while ((req0 || req1) && n < 20) begin
      @(negedge clk);
      n++;
      if (ack0) begin t0 = n; req0 = 0; end
      if (ack1) begin t1 = n; req1 = 0; end
    end
    req0 = 0;
    req1 = 0;
    chk("pair_ack0_time", t0, 2);
    chk("pair_ack1_time", t1, 5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", {20'd0, ack0, ack1, busy, oflow, result}, 0);
    end
    single(0, 4, 2, 4, 8'h08, 0);
    single(1, 15, 15, 15, 8'hE1, 1);
    pair(2, 3, 8'h06, 0, 5, 4, 8'h14, 1);
    pair(1, 1, 8'h01, 0, 0, 0, 8'h00, 0);
    pair(15, 1, 8'h0F, 0, 8, 2, 8'h10, 1);
    @(negedge clk);
    a0 = 3; b0 = 5; req0 = 1;
    @(negedge clk);
    chk("busy_before_rst", {31'd0, busy}, 1);
    rst = 1; req0 = 0;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_outputs", {20'd0, ack0, ack1, busy, oflow, result}, 0);
    repeat (3) @(negedge clk);
    chk("rst_no_ack_result", {24'd0, result}, 0);
    single(0, 3, 5, 3, 8'h0F, 0);
    single(0, 3, 3, 7, 8'h09, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one combinational `multiplicador` datapath between two requesters. It arbitrates round-robin, registers the operands and the product, and returns the result with a one-cycle acknowledge to the granted requester. It sits between the two client blocks and the multiplier instance, so neither client drives the multiplier directly.

## Interface
- `BIT`, default 4: operand width; the product is `2*BIT` bits.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `req0`, input, 1: requester 0 request; a level held until `ack0`.
- `a0`, input, BIT: requester 0 operand A; stable while `req0` is high.
- `b0`, input, BIT: requester 0 operand B.
- `req1`, input, 1: requester 1 request.
- `a1`, input, BIT: requester 1 operand A.
- `b1`, input, BIT: requester 1 operand B.
- `ack0`, output, 1: one-cycle pulse; `result`/`oflow` are valid for requester 0.
- `ack1`, output, 1: one-cycle pulse; `result`/`oflow` are valid for requester 1.
- `result`, output, 2*BIT: registered product, shared by both requesters.
- `oflow`, output, 1: registered; 1 when `result[2*BIT-1:BIT] != 0`, i.e. the product does not fit in BIT bits.
- `busy`, output, 1: high in every state other than IDLE.

## Operation
- FSM states are IDLE, EXEC and DONE.
- IDLE
  - No request: stay in IDLE.
  - Any request: choose a winner, latch its operands into `opa`/`opb`, register `grant`, go to EXEC.
- EXEC
  - The multiplier inputs come from `opa`/`opb`.
  - Capture the multiplier outputs into `result` and `oflow`, then go to DONE.
- DONE
  - Assert `ack[grant]`; `result` and `oflow` hold the product.
  - Update `last_grant <= grant`, then go to IDLE unconditionally.
- Arbitration
  - Only `req0` high: requester 0 wins. Only `req1` high: requester 1 wins.
  - Both high: the requester not equal to `last_grant` wins.
- Requester rule: drop `reqN` on the edge after `ackN` is seen. The arbiter does not check this rule. A request still high in IDLE is treated as a new request.
- Operands are sampled only in IDLE. Operand changes during EXEC or DONE have no effect.
- `result` and `oflow` hold their value after DONE until the next EXEC capture. They are qualified only by `ack0`/`ack1`.
- Arithmetic is unsigned. The full `2*BIT` product is returned; nothing is truncated.

## Timing
- Reset values: state=IDLE, `ack0`=`ack1`=0, `busy`=0, `result`=0, `oflow`=0, `grant`=0, `last_grant`=1 (requester 0 wins the first tie).
- Latency: if a request is seen in IDLE in cycle n, then EXEC is cycle n+1, `ack` is high in cycle n+2, and IDLE returns in cycle n+3.
- Throughput: one multiplication per 3 cycles.
- Back-to-back: a pending request from the other requester is granted in the IDLE cycle n+3, so its `ack` is at n+5.
- Reset mid-operation (EXEC or DONE): next cycle is IDLE with all reset values. No `ack` is issued, and the interrupted requester must re-request.
- `ack0` and `ack1` are never high in the same cycle. `busy` is never high in IDLE.

## Structure
- Package `mult_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, EXEC, DONE} arb_state_t`.
  - Grant encoding constants `GNT_R0=1'b0`, `GNT_R1=1'b1`.
- One sub-module, the existing `multiplicador #(BIT)`, instantiated once:
  - `num1=opa`, `num2=opb`.
  - Its `Result` and `OFLOW` are registered only in EXEC.
  - `oflow` is taken from `OFLOW`, which must match the definition above.
- The arbitration function (2-input round-robin with tie-break) is a separate combinational block inside the module.

## Test plan
- Reset, then idle for 5 cycles -> all outputs 0, `busy`=0, no `ack`.
- `req0`, a0=4, b0=2 (BIT=4) -> `ack0` at n+2 with `result`=8'h08, `oflow`=0; `busy` high for cycles n+1..n+2.
- `req1`, a1=15, b1=15 -> `ack1` at n+2 with `result`=8'hE1, `oflow`=1.
- `req0` and `req1` raised in the same cycle, repeated 3 times -> grants alternate 0,1,0,1,0,1. `ack` pulses are 3 cycles apart, never overlap, and each carries its own product.
- `rst` pulsed during EXEC of a 3×5 request -> no `ack`, `result`=0. A re-request then returns 8'h0F with the normal 2-cycle latency.
- a0 changed from 3 to 7 during EXEC for a 3×3 request -> `result`=8'h09 (operands latched in IDLE only).
